// File: rtl/sqrt_arbiter_if.sv
// Bundle between requesters, the sqrt arbiter and the shared sqrt unit.
// rsp_err exists only when SQRT_ARB_TIMEOUT_EN is defined.
interface sqrt_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int MAG_W   = 32,
   parameter int RES_W   = 16
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*MAG_W-1:0] mag_in;
   logic [NUM_REQ-1:0]       gnt;
   logic [NUM_REQ-1:0]       rsp_vld;
   logic [RES_W-1:0]         rsp_root;
   logic                     busy;
   logic                     sq_go;
   logic [MAG_W-1:0]         sq_mag;
   logic                     sq_done;
   logic [RES_W-1:0]         sq_root;
`ifdef SQRT_ARB_TIMEOUT_EN
   logic                     rsp_err;
`endif

   // slave: the arbiter; master: requesters plus the sqrt unit
   modport slave (
`ifdef SQRT_ARB_TIMEOUT_EN
      output rsp_err,
`endif
      input  req, mag_in, sq_done, sq_root,
      output gnt, rsp_vld, rsp_root, busy, sq_go, sq_mag
   );

   modport master (
`ifdef SQRT_ARB_TIMEOUT_EN
      input  rsp_err,
`endif
      output req, mag_in, sq_done, sq_root,
      input  gnt, rsp_vld, rsp_root, busy, sq_go, sq_mag
   );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one iterative sqrt unit among NUM_REQ requesters.
// Optional watchdog on the sqrt unit enabled by defining SQRT_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for any req; grant, latch operand and fire sq_go on exit
// RUN   | operand held on sq_mag; waiting for sq_done (or watchdog expiry)
// GAP   | rsp_vld pulse cycle; requests ignored, busy cleared on exit
module sqrt_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MAG_W   = 32,
   parameter int RES_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   sqrt_arbiter_if.slave arb_if
);
   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || 2*RES_W != MAG_W || TIMEOUT < 1) begin : g_bad_cfg
      $error("sqrt_arbiter: unsupported parameter combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   pick, idx_nxt;
   logic               found;
   int                 slot;
   logic [MAG_W-1:0]   mag_q, mag_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [RES_W-1:0]   rsp_root_q, rsp_root_d;
   logic               busy_q, busy_d;
   logic               sq_go_q, sq_go_d;
`ifdef SQRT_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic               rsp_err_q, rsp_err_d;
`endif

   // First set request at or above rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      pick  = '0;
      slot  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && arb_if.req[IDX_W'(slot)]) begin
            found = 1'b1;
            pick  = IDX_W'(slot);
         end
      end
   end

   assign idx_nxt = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      idx_d      = idx_q;
      mag_d      = mag_q;
      gnt_d      = '0;
      sq_go_d    = 1'b0;
      rsp_vld_d  = '0;
      rsp_root_d = rsp_root_q;
      busy_d     = busy_q;
`ifdef SQRT_ARB_TIMEOUT_EN
      tmr_d      = tmr_q;
      rsp_err_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (found) begin
               idx_d        = pick;
               mag_d        = arb_if.mag_in[pick*MAG_W +: MAG_W];
               gnt_d[pick]  = 1'b1;
               sq_go_d      = 1'b1;
               busy_d       = 1'b1;
               state_d      = RUN;
`ifdef SQRT_ARB_TIMEOUT_EN
               tmr_d        = TMR_W'(TIMEOUT - 1);
`endif
            end
         end
         RUN: begin
            if (arb_if.sq_done) begin
               rsp_root_d       = arb_if.sq_root;
               rsp_vld_d[idx_q] = 1'b1;
               rr_ptr_d         = idx_nxt;
               state_d          = GAP;
            end
`ifdef SQRT_ARB_TIMEOUT_EN
            else if (tmr_q == '0) begin
               rsp_root_d       = '1;
               rsp_vld_d[idx_q] = 1'b1;
               rsp_err_d        = 1'b1;
               rr_ptr_d         = idx_nxt;
               state_d          = GAP;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
`endif
         end
         GAP: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         idx_q      <= '0;
         mag_q      <= '0;
         gnt_q      <= '0;
         rsp_vld_q  <= '0;
         rsp_root_q <= '0;
         busy_q     <= 1'b0;
         sq_go_q    <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
         tmr_q      <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         idx_q      <= idx_d;
         mag_q      <= mag_d;
         gnt_q      <= gnt_d;
         rsp_vld_q  <= rsp_vld_d;
         rsp_root_q <= rsp_root_d;
         busy_q     <= busy_d;
         sq_go_q    <= sq_go_d;
`ifdef SQRT_ARB_TIMEOUT_EN
         tmr_q      <= tmr_d;
         rsp_err_q  <= rsp_err_d;
`endif
      end
   end

   assign arb_if.gnt      = gnt_q;
   assign arb_if.rsp_vld  = rsp_vld_q;
   assign arb_if.rsp_root = rsp_root_q;
   assign arb_if.busy     = busy_q;
   assign arb_if.sq_go    = sq_go_q;
   assign arb_if.sq_mag   = mag_q;
`ifdef SQRT_ARB_TIMEOUT_EN
   assign arb_if.rsp_err  = rsp_err_q;
`endif
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: behavioural sqrt unit, round-robin reference model,
// directed scenarios plus randomized request mixes.
module tb_sqrt_arbiter;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sqrt_arbiter_if #(.NUM_REQ(N), .MAG_W(32), .RES_W(16)) ifc ();

   sqrt_arbiter #(.NUM_REQ(N), .MAG_W(32), .RES_W(16), .TIMEOUT(64)) dut (
      .clk    (clk),
      .rst    (rst),
      .arb_if (ifc.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] isqrt(input logic [31:0] m);
      longint r;
      r = longint'($sqrt(real'(m)));
      while (r * r > longint'(m)) r--;
      while ((r + 1) * (r + 1) <= longint'(m)) r++;
      return 16'(r);
   endfunction

   // Reference: pending requests as a bit set, pointer as a plain integer
   logic [N-1:0] pend = '0;
   logic [31:0]  mags [N];
   int           ptr = 0;
   int           last_gnt_wait;

   function automatic int pick(input logic [N-1:0] mask, input int p);
      for (int k = 0; k < N; k++)
         if (mask[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic drive();
      ifc.req = pend;
      for (int i = 0; i < N; i++) ifc.mag_in[i*32 +: 32] = mags[i];
   endtask

   // Behavioural sqrt unit
   int          lat      = 18;
   bit          stall    = 1'b0;
   bit          spurious = 1'b0;
   initial begin
      int          cnt;
      bit          busy_u;
      logic [31:0] m;
      busy_u = 1'b0; cnt = 0; m = '0;
      ifc.sq_done = 1'b0;
      ifc.sq_root = '0;
      forever begin
         @(negedge clk);
         ifc.sq_done = 1'b0;
         ifc.sq_root = 16'($urandom);
         if (rst) busy_u = 1'b0;
         else if (spurious) begin
            ifc.sq_done = 1'b1;
            ifc.sq_root = 16'h1234;
         end else if (ifc.sq_go) begin
            busy_u = 1'b1; cnt = lat; m = ifc.sq_mag;
         end else if (busy_u) begin
            chk("sq_mag_hold", 64'(ifc.sq_mag), 64'(m));
            if (cnt <= 1 && !stall) begin
               ifc.sq_done = 1'b1;
               ifc.sq_root = isqrt(m);
               busy_u = 1'b0;
            end else cnt--;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      pend = '0; drive();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; ptr = 0; stall = 1'b0;
   endtask

   task automatic serve(input bit keep, input bit mutate, input logic [31:0] mval, input bit wd);
      int          w, n, j;
      logic [31:0] em;
      w = pick(pend, ptr);
      n = 0;
      while (ifc.gnt == '0 && n < 20) begin @(negedge clk); n++; end
      last_gnt_wait = n;
      chk("gnt", 64'(ifc.gnt), (w < 0) ? 64'd0 : 64'(1) << w);
      if (w < 0) return;
      chk("sq_go", 64'(ifc.sq_go), 64'd1);
      chk("busy_at_gnt", 64'(ifc.busy), 64'd1);
      chk("sq_mag_at_gnt", 64'(ifc.sq_mag), 64'(mags[w]));
      em = mags[w];
      if (mutate) mags[w] = mval;
      if (wd) begin
         j = $urandom_range(0, N - 1);
         if (j != w) pend[j] = 1'b0;
      end
      drive();
      @(negedge clk);
      chk("gnt_pulse", 64'(ifc.gnt), 64'd0);
      chk("sq_go_pulse", 64'(ifc.sq_go), 64'd0);
      n = 0;
      while (ifc.rsp_vld == '0 && n < 300) begin @(negedge clk); n++; end
      chk("rsp_vld", 64'(ifc.rsp_vld), 64'(1) << w);
      chk("rsp_root", 64'(ifc.rsp_root), 64'(isqrt(em)));
      chk("busy_at_rsp", 64'(ifc.busy), 64'd1);
`ifdef SQRT_ARB_TIMEOUT_EN
      chk("rsp_err_ok", 64'(ifc.rsp_err), 64'd0);
`endif
      if (!keep) pend[w] = 1'b0;
      drive();
      ptr = (w + 1) % N;
      @(negedge clk);
      chk("busy_drop", 64'(ifc.busy), 64'd0);
      chk("rsp_vld_pulse", 64'(ifc.rsp_vld), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, seen;
      logic [15:0] prev_root;
      for (int i = 0; i < N; i++) mags[i] = '0;
      drive();
      repeat (2) @(negedge clk);
      chk("rst_gnt", 64'(ifc.gnt), 64'd0);
      chk("rst_rsp_vld", 64'(ifc.rsp_vld), 64'd0);
      chk("rst_busy", 64'(ifc.busy), 64'd0);
      chk("rst_sq_go", 64'(ifc.sq_go), 64'd0);
      chk("rst_rsp_root", 64'(ifc.rsp_root), 64'd0);
      chk("rst_sq_mag", 64'(ifc.sq_mag), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // single request, gnt latency
      mags[0] = 144; pend = 4'b0001; drive();
      serve(0, 0, 0, 0);
      chk("gnt_latency", 64'(last_gnt_wait), 64'd1);

      // operand must stay latched after mag_in changes
      mags[2] = 1000000; pend = 4'b0100; drive();
      serve(0, 1, 32'd5, 0);

      // all four at once from reset: order 0,1,2,3
      do_reset();
      mags[0] = 4; mags[1] = 9; mags[2] = 16; mags[3] = 25;
      pend = 4'b1111; drive();
      for (int i = 0; i < N; i++) serve(0, 0, 0, 0);

      // pointer at 2 after serving 1, then 0 before 1, 0 held high
      do_reset();
      mags[1] = 32'hFFFF_FFFF; pend = 4'b0010; drive();
      serve(0, 0, 0, 0);
      chk("rr_ptr_model", 64'(ptr), 64'd2);
      mags[0] = 0; mags[1] = 100; pend = 4'b0011; drive();
      serve(1, 0, 0, 0);
      serve(0, 0, 0, 0);
      serve(0, 0, 0, 0);

      // stray sq_done in IDLE is ignored
      prev_root = ifc.rsp_root;
      seen = 0;
      spurious = 1'b1;
      repeat (2) begin @(negedge clk); if (ifc.rsp_vld != '0) seen++; end
      spurious = 1'b0;
      repeat (2) begin @(negedge clk); if (ifc.rsp_vld != '0) seen++; end
      chk("idle_done_vld", 64'(seen), 64'd0);
      chk("idle_done_root", 64'(ifc.rsp_root), 64'(prev_root));
      chk("idle_done_busy", 64'(ifc.busy), 64'd0);

      // reset 5 cycles into RUN
      lat = 20; mags[2] = 400; pend = 4'b0100; drive();
      n = 0;
      while (ifc.gnt == '0 && n < 20) begin @(negedge clk); n++; end
      chk("mid_gnt", 64'(ifc.gnt), 64'b0100);
      repeat (5) @(negedge clk);
      pend = '0; drive(); rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_gnt", 64'(ifc.gnt), 64'd0);
      chk("mid_rst_rsp_vld", 64'(ifc.rsp_vld), 64'd0);
      chk("mid_rst_busy", 64'(ifc.busy), 64'd0);
      chk("mid_rst_sq_go", 64'(ifc.sq_go), 64'd0);
      chk("mid_rst_rsp_root", 64'(ifc.rsp_root), 64'd0);
      chk("mid_rst_sq_mag", 64'(ifc.sq_mag), 64'd0);
`ifdef SQRT_ARB_TIMEOUT_EN
      chk("mid_rst_rsp_err", 64'(ifc.rsp_err), 64'd0);
`endif
      rst = 1'b0; ptr = 0;
      seen = 0;
      repeat (30) begin @(negedge clk); if (ifc.rsp_vld != '0) seen++; end
      chk("no_rsp_after_rst", 64'(seen), 64'd0);
      mags[3] = 49; pend = 4'b1000; drive();
      serve(0, 0, 0, 0);

      // randomized request mixes
      for (int it = 0; it < 25; it++) begin
         int s;
         logic [N-1:0] nb;
         lat = $urandom_range(1, 24);
         nb = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++)
            if (nb[i] && !pend[i])
               mags[i] = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 1000));
         pend = pend | nb; drive();
         s = 0;
         while (pend != '0 && s < 16) begin
            serve((s < 6) && ($urandom % 4 == 0), $urandom % 2, $urandom,
                  $urandom % 4 == 0);
            s++;
         end
      end

      // stuck sqrt unit
      do_reset();
      stall = 1'b1; lat = 5; mags[1] = 81; pend = 4'b0010; drive();
      n = 0;
      while (ifc.gnt == '0 && n < 20) begin @(negedge clk); n++; end
      chk("to_gnt", 64'(ifc.gnt), 64'b0010);
`ifdef SQRT_ARB_TIMEOUT_EN
      n = 0;
      while (ifc.rsp_vld == '0 && n < 200) begin @(negedge clk); n++; end
      chk("to_cycles", 64'(n), 64'd64);
      chk("to_rsp_vld", 64'(ifc.rsp_vld), 64'b0010);
      chk("to_rsp_root", 64'(ifc.rsp_root), 64'hFFFF);
      chk("to_rsp_err", 64'(ifc.rsp_err), 64'd1);
      pend = '0; drive();
      @(negedge clk);
      chk("to_rsp_err_pulse", 64'(ifc.rsp_err), 64'd0);
      chk("to_busy_drop", 64'(ifc.busy), 64'd0);
`else
      seen = 0;
      repeat (100) begin @(negedge clk); if (ifc.rsp_vld != '0) seen++; end
      chk("stuck_no_rsp", 64'(seen), 64'd0);
      chk("stuck_busy", 64'(ifc.busy), 64'd1);
`endif
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
